// File: rtl/product_accumulator_if.sv
// Handshake bundle for product_accumulator: the product beat stream in and the frame result out.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface product_accumulator_if #(
  parameter int ACC_BITS = 24,
  parameter int CNT_BITS = 10
) ();

  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_p;
  logic                in_sgnd;
  logic                in_last;

  logic                out_valid;
  logic                out_ready;
  logic [ACC_BITS-1:0] out_acc;
  logic [CNT_BITS-1:0] out_count;
  logic                out_overflow;

  modport slave (
    input  in_valid,
    input  in_p,
    input  in_sgnd,
    input  in_last,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_acc,
    output out_count,
    output out_overflow
  );

  modport master (
    output in_valid,
    output in_p,
    output in_sgnd,
    output in_last,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_acc,
    input  out_count,
    input  out_overflow
  );

endinterface

// File: rtl/product_accumulator.sv
// Frame accumulator for 16-bit multiplier products; emits the frame sum, term count and overflow flag.
// Optional `define ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_BITS = 24,
  parameter int CNT_BITS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic soft_clr,
  product_accumulator_if.slave bus
);

  localparam int MSB = ACC_BITS - 1;
  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t              state;
  logic [ACC_BITS-1:0] acc;
  logic [CNT_BITS-1:0] count;
  logic                ovf;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [ACC_BITS-1:0] ext;
  logic [ACC_BITS-1:0] sum;
  logic                ovf_now;
  logic [ACC_BITS-1:0] acc_next;
  logic [CNT_BITS-1:0] count_next;
  logic                beat_accept;

  // Overflow is detected on the wrapped sum: same-sign operands yielding a different-sign result.
  always_comb begin
    ext         = '0;
    sum         = '0;
    ovf_now     = 1'b0;
    acc_next    = '0;
    count_next  = '0;
    beat_accept = bus.in_valid & in_ready_q;

    if (bus.in_sgnd) begin
      ext = {{(ACC_BITS-16){bus.in_p[15]}}, bus.in_p};
    end else begin
      ext = {{(ACC_BITS-16){1'b0}}, bus.in_p};
    end

    sum     = acc + ext;
    ovf_now = (acc[MSB] == ext[MSB]) && (sum[MSB] != acc[MSB]);

`ifdef ACC_SAT_EN
    if (ovf_now) begin
      acc_next = acc[MSB] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum;
    end
`else
    acc_next = sum;
`endif

    if (count == CNT_MAX) begin
      count_next = count;
    end else begin
      count_next = count + 1'b1;
    end
  end

  // soft_clr outranks both handshakes; a beat offered alongside it is simply not consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (soft_clr) begin
      state       <= ST_ACC;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (beat_accept) begin
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf | ovf_now;
            if (bus.in_last) begin
              state       <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_ACC;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ST_ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_acc      = acc;
  assign bus.out_count    = count;
  assign bus.out_overflow = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator with hand-computed frame sums.
// Expected overflow-frame sums follow ACC_SAT_EN when the same define is given to the bench.
module tb_product_accumulator;

  localparam int ACC_BITS = 24;
  localparam int CNT_BITS = 10;

  logic clk;
  logic rst_n;
  logic soft_clr;

  int compared;
  int mismatched;

  product_accumulator_if #(.ACC_BITS(ACC_BITS), .CNT_BITS(CNT_BITS)) bus ();

  product_accumulator #(.ACC_BITS(ACC_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_clr (soft_clr),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge so the DUT samples them cleanly at the next rising edge.
  task automatic applyStimulus(input logic [15:0] p, input logic sgnd, input logic last);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_sgnd  = sgnd;
    bus.in_last  = last;
  endtask

  task automatic goIdle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_p     = 16'h0000;
  endtask

  task automatic sendFrame(input int n, input logic [15:0] p, input logic sgnd);
    for (int i = 0; i < n; i++) begin
      applyStimulus(p, sgnd, (i == n - 1));
    end
    goIdle();
  endtask

  // Called on the falling edge right after the last beat was taken: the result must already be up.
  task automatic checkResult(input string tag, input logic [ACC_BITS-1:0] acc,
                             input logic [CNT_BITS-1:0] cnt, input logic ovf);
    checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, "_inrdy"}, 64'(bus.in_ready), 64'd0);
    checkOutput({tag, "_acc"}, 64'(bus.out_acc), 64'(acc));
    checkOutput({tag, "_cnt"}, 64'(bus.out_count), 64'(cnt));
    checkOutput({tag, "_ovf"}, 64'(bus.out_overflow), 64'(ovf));
  endtask

  task automatic drainResult(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_drain_inrdy"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_drain_cnt"}, 64'(bus.out_count), 64'd0);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    soft_clr      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_p      = 16'h0000;
    bus.in_sgnd   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    checkOutput("rst_inrdy", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_acc", 64'(bus.out_acc), 64'd0);
    checkOutput("rst_cnt", 64'(bus.out_count), 64'd0);
    checkOutput("rst_ovf", 64'(bus.out_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned 255*255 twice, with an idle gap carrying a stray in_last in between.
    applyStimulus(16'hFE01, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    @(negedge clk);
    checkOutput("gap_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("gap_cnt", 64'(bus.out_count), 64'd1);
    checkOutput("gap_acc", 64'(bus.out_acc), 64'h00FE01);
    bus.in_valid = 1'b1;
    bus.in_p     = 16'hFE01;
    bus.in_sgnd  = 1'b0;
    bus.in_last  = 1'b1;
    goIdle();
    checkResult("unsigned2", 24'h01FC02, 10'd2, 1'b0);
    drainResult("unsigned2");

    // Signed -128 + 100.
    applyStimulus(16'hFF80, 1'b1, 1'b0);
    applyStimulus(16'h0064, 1'b1, 1'b1);
    goIdle();
    checkResult("signed2", 24'hFFFFE4, 10'd2, 1'b0);
    drainResult("signed2");

    // Mixed signedness: 65535 unsigned plus -1 signed.
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    goIdle();
    checkResult("mixed", 24'h00FFFE, 10'd2, 1'b0);
    drainResult("mixed");

    // 512 * 0x4000 crosses +2^23 on the final beat.
    sendFrame(512, 16'h4000, 1'b1);
`ifdef ACC_SAT_EN
    checkResult("posovf", 24'h7FFFFF, 10'd512, 1'b1);
`else
    checkResult("posovf", 24'h800000, 10'd512, 1'b1);
`endif
    drainResult("posovf");

    // 512 * -0x4000 lands exactly on -2^23; one more term overflows negatively.
    sendFrame(513, 16'hC000, 1'b1);
`ifdef ACC_SAT_EN
    checkResult("negovf", 24'h800000, 10'd513, 1'b1);
`else
    checkResult("negovf", 24'h7FC000, 10'd513, 1'b1);
`endif
    drainResult("negovf");

    // Term count saturates at 1023.
    sendFrame(1030, 16'h0000, 1'b0);
    checkResult("cntsat", 24'h000000, 10'd1023, 1'b0);
    drainResult("cntsat");

    // Backpressure in DONE: result holds and offered beats are not consumed.
    sendFrame(1, 16'h0003, 1'b0);
    checkResult("single", 24'h000003, 10'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_p     = 16'h0100;
      bus.in_last  = 1'b1;
      @(negedge clk);
      checkResult("hold", 24'h000003, 10'd1, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drainResult("hold");
    sendFrame(1, 16'h0009, 1'b0);
    checkResult("afterhold", 24'h000009, 10'd1, 1'b0);
    drainResult("afterhold");

    // soft_clr on the third beat drops that beat and the partial sum.
    applyStimulus(16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0002, 1'b0, 1'b0);
    applyStimulus(16'h0010, 1'b0, 1'b0);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr     = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("sclr_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("sclr_acc", 64'(bus.out_acc), 64'd0);
    checkOutput("sclr_cnt", 64'(bus.out_count), 64'd0);
    sendFrame(1, 16'h0005, 1'b0);
    checkResult("aftersclr", 24'h000005, 10'd1, 1'b0);

    // soft_clr while holding a result discards it.
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    checkOutput("sclrdone_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("sclrdone_inrdy", 64'(bus.in_ready), 64'd1);
    checkOutput("sclrdone_acc", 64'(bus.out_acc), 64'd0);

    // Asynchronous reset mid-frame takes effect before any clock edge.
    applyStimulus(16'h0011, 1'b0, 1'b0);
    applyStimulus(16'h0022, 1'b0, 1'b0);
    goIdle();
    checkOutput("prerst_cnt", 64'(bus.out_count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_cnt", 64'(bus.out_count), 64'd0);
    checkOutput("arst_acc", 64'(bus.out_acc), 64'd0);
    checkOutput("arst_inrdy", 64'(bus.in_ready), 64'd1);
    checkOutput("arst_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sendFrame(1, 16'h0007, 1'b0);
    checkResult("afterrst", 24'h000007, 10'd1, 1'b0);
    drainResult("afterrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
